// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and elaboration helpers for the button
//               conditioner (state encoding, prescaler terminal count,
//               parameter legality check).
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_e;

    // Number of clk cycles in one millisecond.
    function automatic int calc_clks_per_ms(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    // True when the parameter set is legal. The top level turns a false
    // result into an elaboration-time $error.
    function automatic bit params_legal(
        input int num_btn,
        input int clk_freq_hz,
        input int debounce_ms,
        input int long_ms,
        input int repeat_ms
    );
        bit ok;
        ok = 1'b1;
        if (num_btn < 1)                      ok = 1'b0;
        if ((clk_freq_hz % 1000) != 0)        ok = 1'b0;
        if (calc_clks_per_ms(clk_freq_hz) < 2) ok = 1'b0;
        if (debounce_ms < 1)                  ok = 1'b0;
        if (long_ms <= debounce_ms)           ok = 1'b0;
        if (repeat_ms < 1)                    ok = 1'b0;
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module      : btn_channel
// Description : One button channel: 2-FF synchroniser, millisecond debounce
//               counter, IDLE/PRESSED/LONG state machine with hold and
//               auto-repeat counters. All pulse outputs are registered.
// Ports       : clk, reset (async, active-low), i_ms_tick (shared 1 ms
//               strobe), i_btn (raw level), i_repeat_en, o_level, o_press,
//               o_release, o_long, o_repeat
// Revision    : 1.0 - initial release
// ============================================================================
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TIME_MS = 20,
    parameter int LONG_PRESS_MS    = 1000,
    parameter int REPEAT_MS        = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ms_tick,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_TIME_MS + 1);
    localparam int c_HOLD_W = $clog2(LONG_PRESS_MS + 1);
    localparam int c_REP_W  = $clog2(REPEAT_MS + 1);

    // Counters act on the tick that makes them reach their limit, so the
    // compare value is limit-1.
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_TIME_MS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_PRESS_MS - 1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_MS - 1);

    localparam logic [1:0] c_ST_IDLE    = IDLE;
    localparam logic [1:0] c_ST_PRESSED = PRESSED;
    localparam logic [1:0] c_ST_LONG    = LONG;

    logic                r_meta;
    logic                r_sync;
    logic                r_level;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_REP_W-1:0]  r_rep_cnt;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic                r_repeat;

    logic w_differs;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    // Any cycle at the current level clears the count, so a single-cycle
    // glitch back restarts the whole debounce interval.
    assign w_differs = (r_sync != r_level);
    assign w_flip    = w_differs && i_ms_tick && (r_db_cnt == c_DB_LAST);
    assign w_rise    = w_flip && !r_level;
    assign w_fall    = w_flip &&  r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            if (!w_differs || w_flip) begin
                r_db_cnt <= '0;
            end else if (i_ms_tick) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            r_level <= r_level ^ w_flip;
        end
    end

    // A fall is tested before any threshold so that release wins a tie with
    // the long-press or repeat tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rise) begin
                        r_press    <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= c_ST_PRESSED;
                    end
                end
                c_ST_PRESSED: begin
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else if (i_ms_tick) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_long     <= 1'b1;
                            r_hold_cnt <= '0;
                            r_rep_cnt  <= '0;
                            r_state    <= c_ST_LONG;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                c_ST_LONG: begin
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else if (!i_repeat_en) begin
                        // Held at zero so re-enabling starts a full interval.
                        r_rep_cnt <= '0;
                    end else if (i_ms_tick) begin
                        if (r_rep_cnt == c_REP_LAST) begin
                            r_repeat  <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : NUM_BTN-channel button front end. One shared millisecond
//               prescaler drives NUM_BTN independent btn_channel instances
//               (sync, debounce, press/release/long/repeat pulses).
// Ports       : clk, reset (async, active-low), i_btn[NUM_BTN],
//               i_repeat_en[NUM_BTN], o_level/o_press/o_release/o_long/
//               o_repeat[NUM_BTN]
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN          = 2,
    parameter int CLK_FREQ_HZ      = 100_000_000,
    parameter int DEBOUNCE_TIME_MS = 20,
    parameter int LONG_PRESS_MS    = 1000,
    parameter int REPEAT_MS        = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] i_btn,
    input  logic [NUM_BTN-1:0] i_repeat_en,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long,
    output logic [NUM_BTN-1:0] o_repeat
);

    localparam int c_CLKS_PER_MS = calc_clks_per_ms(CLK_FREQ_HZ);
    localparam int c_PRESC_W     = $clog2(c_CLKS_PER_MS);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(c_CLKS_PER_MS - 1);

    if (!params_legal(NUM_BTN, CLK_FREQ_HZ, DEBOUNCE_TIME_MS,
                      LONG_PRESS_MS, REPEAT_MS)) begin : g_param_error
        $error("button_conditioner: illegal parameter set");
    end

    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_ms_tick;

    // Tick is a decode of the terminal count, high for exactly one cycle.
    assign w_ms_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_ms_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_TIME_MS (DEBOUNCE_TIME_MS),
            .LONG_PRESS_MS    (LONG_PRESS_MS),
            .REPEAT_MS        (REPEAT_MS)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .i_ms_tick   (w_ms_tick),
            .i_btn       (i_btn[gi]),
            .i_repeat_en (i_repeat_en[gi]),
            .o_level     (o_level[gi]),
            .o_press     (o_press[gi]),
            .o_release   (o_release[gi]),
            .o_long      (o_long[gi]),
            .o_repeat    (o_repeat[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner. A monitor logs
//               every output pulse; each test pushes the pulses it expects
//               (channel, kind, cycle window) and then drains both queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_NUM = 2;
    localparam int c_K_PRESS = 0;
    localparam int c_K_REL   = 1;
    localparam int c_K_LONG  = 2;
    localparam int c_K_REP   = 3;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } obs_t;

    typedef struct {
        int ch;
        int kind;
        bit rel;   // window relative to the previous observed pulse
        int lo;
        int hi;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [c_NUM-1:0] btn = '0;
    logic [c_NUM-1:0] rep_en = '0;
    logic [c_NUM-1:0] level, press, rel_p, lng, rpt;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    obs_t q_obs[$];
    exp_t q_exp[$];

    button_conditioner #(
        .NUM_BTN          (c_NUM),
        .CLK_FREQ_HZ      (100_000),
        .DEBOUNCE_TIME_MS (2),
        .LONG_PRESS_MS    (10),
        .REPEAT_MS        (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn       (btn),
        .i_repeat_en (rep_en),
        .o_level     (level),
        .o_press     (press),
        .o_release   (rel_p),
        .o_long      (lng),
        .o_repeat    (rpt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < c_NUM; c++) begin
            if (press[c]) q_obs.push_back('{cyc, c, c_K_PRESS});
            if (rel_p[c]) q_obs.push_back('{cyc, c, c_K_REL});
            if (lng[c])   q_obs.push_back('{cyc, c, c_K_LONG});
            if (rpt[c])   q_obs.push_back('{cyc, c, c_K_REP});
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int ch, input int kind, input bit rel,
                            input int lo, input int hi);
        q_exp.push_back('{ch, kind, rel, lo, hi});
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        wait_clks(5);
        n_chk++;
        if ({level, press, rel_p, lng, rpt} !== '0)
            $display("FAIL reset_outputs: got %b, want 0", {level, press, rel_p, lng, rpt});
        else n_pass++;
        reset = 1'b1;
        wait_clks(300);
        n_chk++;
        if (level !== 2'b00 || q_obs.size() != 0)
            $display("FAIL reset_idle: got level %b pulses %0d, want 00 and 0", level, q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    task automatic test_clean_press();
        exp_t e; obs_t o; int prev, lo, hi, b;
        prev = 0;
        rep_en = 2'b00;
        b = cyc; btn[0] = 1'b1;
        push_exp(0, c_K_PRESS, 1'b0, b + 101, b + 202);
        push_exp(0, c_K_LONG,  1'b1, 1000, 1000);
        wait_clks(5000);
        n_chk++;
        if (level[0] !== 1'b1) $display("FAIL clean_level_high: got %b, want 1", level[0]);
        else n_pass++;
        b = cyc; btn[0] = 1'b0;
        push_exp(0, c_K_REL, 1'b0, b + 101, b + 202);
        wait_clks(400);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_chk++;
            if (q_obs.size() == 0) begin
                $display("FAIL clean_press: got no pulse, want ch%0d kind %0d", e.ch, e.kind);
            end else begin
                o = q_obs.pop_front();
                lo = e.rel ? prev + e.lo : e.lo;
                hi = e.rel ? prev + e.hi : e.hi;
                if (o.ch !== e.ch || o.kind !== e.kind || o.cyc < lo || o.cyc > hi)
                    $display("FAIL clean_press: got ch%0d kind %0d @%0d, want ch%0d kind %0d @%0d..%0d",
                             o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
                else n_pass++;
                prev = o.cyc;
            end
        end
        n_chk++;
        if (q_obs.size() != 0) $display("FAIL clean_press_extra: got %0d extra pulses, want 0", q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    task automatic test_bounce();
        exp_t e; obs_t o; int prev, lo, hi, b;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            btn[0] = ~btn[0];
            wait_clks(50);
        end
        b = cyc; btn[0] = 1'b1;
        push_exp(0, c_K_PRESS, 1'b0, b + 101, b + 202);
        wait_clks(300);
        b = cyc; btn[0] = 1'b0;
        push_exp(0, c_K_REL, 1'b0, b + 101, b + 202);
        wait_clks(400);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_chk++;
            if (q_obs.size() == 0) begin
                $display("FAIL bounce: got no pulse, want ch%0d kind %0d", e.ch, e.kind);
            end else begin
                o = q_obs.pop_front();
                lo = e.rel ? prev + e.lo : e.lo;
                hi = e.rel ? prev + e.hi : e.hi;
                if (o.ch !== e.ch || o.kind !== e.kind || o.cyc < lo || o.cyc > hi)
                    $display("FAIL bounce: got ch%0d kind %0d @%0d, want ch%0d kind %0d @%0d..%0d",
                             o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
                else n_pass++;
                prev = o.cyc;
            end
        end
        n_chk++;
        if (q_obs.size() != 0) $display("FAIL bounce_extra: got %0d extra pulses, want 0", q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    task automatic test_auto_repeat();
        exp_t e; obs_t o; int prev, lo, hi, b;
        prev = 0;
        rep_en = 2'b10;
        b = cyc; btn[1] = 1'b1;
        push_exp(1, c_K_PRESS, 1'b0, b + 101, b + 202);
        push_exp(1, c_K_LONG,  1'b1, 1000, 1000);
        for (int i = 0; i < 3; i++) push_exp(1, c_K_REP, 1'b1, 300, 300);
        wait_clks(2000);
        b = cyc; btn[1] = 1'b0;
        push_exp(1, c_K_REL, 1'b0, b + 101, b + 202);
        wait_clks(600);
        rep_en = 2'b00;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_chk++;
            if (q_obs.size() == 0) begin
                $display("FAIL auto_repeat: got no pulse, want ch%0d kind %0d", e.ch, e.kind);
            end else begin
                o = q_obs.pop_front();
                lo = e.rel ? prev + e.lo : e.lo;
                hi = e.rel ? prev + e.hi : e.hi;
                if (o.ch !== e.ch || o.kind !== e.kind || o.cyc < lo || o.cyc > hi)
                    $display("FAIL auto_repeat: got ch%0d kind %0d @%0d, want ch%0d kind %0d @%0d..%0d",
                             o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
                else n_pass++;
                prev = o.cyc;
            end
        end
        n_chk++;
        if (q_obs.size() != 0) $display("FAIL auto_repeat_extra: got %0d extra pulses, want 0", q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    task automatic test_short_press();
        exp_t e; obs_t o; int prev, lo, hi, b;
        prev = 0;
        b = cyc; btn[0] = 1'b1;
        push_exp(0, c_K_PRESS, 1'b0, b + 101, b + 202);
        wait_clks(500);
        b = cyc; btn[0] = 1'b0;
        push_exp(0, c_K_REL, 1'b0, b + 101, b + 202);
        wait_clks(400);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_chk++;
            if (q_obs.size() == 0) begin
                $display("FAIL short_press: got no pulse, want ch%0d kind %0d", e.ch, e.kind);
            end else begin
                o = q_obs.pop_front();
                lo = e.rel ? prev + e.lo : e.lo;
                hi = e.rel ? prev + e.hi : e.hi;
                if (o.ch !== e.ch || o.kind !== e.kind || o.cyc < lo || o.cyc > hi)
                    $display("FAIL short_press: got ch%0d kind %0d @%0d, want ch%0d kind %0d @%0d..%0d",
                             o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
                else n_pass++;
                prev = o.cyc;
            end
        end
        n_chk++;
        if (q_obs.size() != 0) $display("FAIL short_press_extra: got %0d extra pulses, want 0", q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    task automatic test_simultaneous();
        exp_t e; obs_t o; int prev, lo, hi, b;
        prev = 0;
        b = cyc; btn = 2'b11;
        push_exp(0, c_K_PRESS, 1'b0, b + 101, b + 202);
        push_exp(1, c_K_PRESS, 1'b1, 0, 0);
        push_exp(0, c_K_LONG,  1'b1, 1000, 1000);
        push_exp(1, c_K_LONG,  1'b1, 0, 0);
        wait_clks(1200);
        b = cyc; btn = 2'b00;
        push_exp(0, c_K_REL, 1'b0, b + 101, b + 202);
        push_exp(1, c_K_REL, 1'b1, 0, 0);
        wait_clks(400);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_chk++;
            if (q_obs.size() == 0) begin
                $display("FAIL simultaneous: got no pulse, want ch%0d kind %0d", e.ch, e.kind);
            end else begin
                o = q_obs.pop_front();
                lo = e.rel ? prev + e.lo : e.lo;
                hi = e.rel ? prev + e.hi : e.hi;
                if (o.ch !== e.ch || o.kind !== e.kind || o.cyc < lo || o.cyc > hi)
                    $display("FAIL simultaneous: got ch%0d kind %0d @%0d, want ch%0d kind %0d @%0d..%0d",
                             o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
                else n_pass++;
                prev = o.cyc;
            end
        end
        n_chk++;
        if (q_obs.size() != 0) $display("FAIL simultaneous_extra: got %0d extra pulses, want 0", q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    // Raw hold lengths are whole milliseconds, so the debounced fall lands
    // on exactly the tick where the long/repeat threshold would be reached.
    task automatic test_release_race();
        exp_t e; obs_t o; int prev, lo, hi, b;
        prev = 0;
        b = cyc; btn[0] = 1'b1;
        push_exp(0, c_K_PRESS, 1'b0, b + 101, b + 202);
        push_exp(0, c_K_REL,   1'b1, 1000, 1000);
        wait_clks(1000);
        btn[0] = 1'b0;
        wait_clks(400);
        rep_en = 2'b10;
        btn[1] = 1'b1;
        push_exp(1, c_K_PRESS, 1'b1, 100, 100000);
        push_exp(1, c_K_LONG,  1'b1, 1000, 1000);
        push_exp(1, c_K_REL,   1'b1, 300, 300);
        wait_clks(1300);
        btn[1] = 1'b0;
        wait_clks(400);
        rep_en = 2'b00;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_chk++;
            if (q_obs.size() == 0) begin
                $display("FAIL release_race: got no pulse, want ch%0d kind %0d", e.ch, e.kind);
            end else begin
                o = q_obs.pop_front();
                lo = e.rel ? prev + e.lo : e.lo;
                hi = e.rel ? prev + e.hi : e.hi;
                if (o.ch !== e.ch || o.kind !== e.kind || o.cyc < lo || o.cyc > hi)
                    $display("FAIL release_race: got ch%0d kind %0d @%0d, want ch%0d kind %0d @%0d..%0d",
                             o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
                else n_pass++;
                prev = o.cyc;
            end
        end
        n_chk++;
        if (q_obs.size() != 0) $display("FAIL release_race_extra: got %0d extra pulses, want 0", q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    task automatic test_reset_mid_hold();
        exp_t e; obs_t o; int prev, lo, hi, b;
        prev = 0;
        b = cyc; btn[0] = 1'b1;
        push_exp(0, c_K_PRESS, 1'b0, b + 101, b + 202);
        wait_clks(600);
        n_chk++;
        if (level[0] !== 1'b1) $display("FAIL midhold_level: got %b, want 1", level[0]);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({level, press, rel_p, lng, rpt} !== '0)
            $display("FAIL midhold_reset_outputs: got %b, want 0", {level, press, rel_p, lng, rpt});
        else n_pass++;
        wait_clks(3);
        reset = 1'b1;
        b = cyc;
        push_exp(0, c_K_PRESS, 1'b0, b + 101, b + 202);
        push_exp(0, c_K_LONG,  1'b1, 1000, 1000);
        wait_clks(1300);
        b = cyc; btn[0] = 1'b0;
        push_exp(0, c_K_REL, 1'b0, b + 101, b + 202);
        wait_clks(400);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_chk++;
            if (q_obs.size() == 0) begin
                $display("FAIL reset_mid_hold: got no pulse, want ch%0d kind %0d", e.ch, e.kind);
            end else begin
                o = q_obs.pop_front();
                lo = e.rel ? prev + e.lo : e.lo;
                hi = e.rel ? prev + e.hi : e.hi;
                if (o.ch !== e.ch || o.kind !== e.kind || o.cyc < lo || o.cyc > hi)
                    $display("FAIL reset_mid_hold: got ch%0d kind %0d @%0d, want ch%0d kind %0d @%0d..%0d",
                             o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
                else n_pass++;
                prev = o.cyc;
            end
        end
        n_chk++;
        if (q_obs.size() != 0) $display("FAIL reset_mid_hold_extra: got %0d extra pulses, want 0", q_obs.size());
        else n_pass++;
        q_obs.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_short_press();
        test_simultaneous();
        test_release_race();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
